// File: rtl/sr_bank_ctrl_pkg.sv
// Shared encodings for set/reset bank sequencers: command codes, FSM states, pulse counter width.
package sr_ctrl_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [1:0]       cmd_t;
  typedef logic [2:0]       state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cmd_t CMD_NOP  = 2'b00;
  localparam cmd_t CMD_CLR  = 2'b01;
  localparam cmd_t CMD_SET  = 2'b10;
  localparam cmd_t CMD_LOAD = 2'b11;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ASSERT  = 3'd1;
  localparam state_t ST_RELEASE = 3'd2;
  localparam state_t ST_CHECK   = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module sr_pulse_timer
  import sr_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  cnt_t load_val_i,
  input  logic dec_i,
  output logic zero_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_bank_ctrl.sv
// Sequencer for a bank of set/reset D flip-flops: timed s/r pulses or masked load.
// Define SR_CHECK_EN to add a read-back CHECK state driving err_o.
module sr_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             nr_i,
  input  logic             req_i,
  input  logic [1:0]       cmd_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] d_o,
  input  logic [WIDTH-1:0] q_i
);

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             load_act;

  assign accept = (state_q == ST_IDLE) && req_i;

  sr_pulse_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (nr_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_t'(PULSE_CYC - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    mask_d   = mask_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          cmd_d  = cmd_i;
          mask_d = mask_i;
          data_d = data_i;
          if (cmd_i == CMD_NOP) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_ASSERT;
            cnt_load = 1'b1;
          end
        end
      end
      ST_ASSERT: begin
        if (cnt_zero) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef SR_CHECK_EN
      ST_RELEASE: state_d = ST_CHECK;
      ST_CHECK:   state_d = ST_DONE;
`else
      ST_RELEASE: state_d = ST_DONE;
`endif
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // s/r are registered from next-state so they switch cleanly on the edge, never from raw inputs.
  always_comb begin
    s_d    = '0;
    r_d    = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_ASSERT) begin
      if (cmd_d == CMD_SET) s_d = mask_d;
      if (cmd_d == CMD_CLR) r_d = mask_d;
    end
  end

  always_ff @(posedge clk_i or negedge nr_i) begin
    if (!nr_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      mask_q  <= '0;
      data_q  <= '0;
      s_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load_act = (state_q == ST_ASSERT) && (cmd_q == CMD_LOAD);
  // Unmasked bits always recirculate q so they hold through any command.
  assign d_o = load_act ? ((data_q & mask_q) | (q_i & ~mask_q)) : q_i;

  assign s_o    = s_q;
  assign r_o    = r_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef SR_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] exp_val;

  always_comb begin
    case (cmd_q)
      CMD_SET:  exp_val = '1;
      CMD_LOAD: exp_val = data_q;
      default:  exp_val = '0;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == ST_CHECK) && (((q_i ^ exp_val) & mask_q) != '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nr_i) begin
    if (!nr_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
